fifo_word_rdr: RTL and testbench
================================

Name: fifo_word_rdr

Overview:
- Read-side engine for the byte-wide sync FIFO; it is the consumer that drains the FIFO on behalf of the QSPI master datapath.
- Accepts a byte-count command and pops that many bytes from a first-word-fall-through FIFO.
- Packs the bytes little-endian into NB-byte words and presents each word on a valid/ready output with byte enables and a last flag.
- Pulses done when the final word is accepted.

Parameters:
W, 8, FIFO data width in bits (one byte lane).
NB, 4, bytes per output word; power of two, 2..8.
BCW, 16, width of command byte count.
NBW, log2(NB), lane index width (derived; NB=4 gives 2).

Ports:
clk  input  1  clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; returns block to IDLE.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
cmd_bcnt  input  BCW  total bytes to read for this command.
fifo_empty  input  1  FIFO empty flag (fast/combinational).
fifo_rd_data  input  W  FIFO head byte; valid whenever !fifo_empty.
fifo_rd_en  output  1  pop FIFO head this cycle.
out_valid  output  1  packed word available.
out_ready  input  1  downstream accepts word.
out_data  output  NB*W  packed word; byte k in bits [k*W +: W].
out_be  output  NB  lane enables; 1 = lane holds a popped byte.
out_last  output  1  final word of the command.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE; fifo_rd_en=0, out_valid=0, out_data=0, out_be=0, out_last=0, busy=0, done=0. Internal state is IDLE, remaining=0, lane=0.
- States: IDLE, FILL, HOLD.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_bcnt!=0: latch remaining=cmd_bcnt, lane=0, clear out_data/out_be, go to FILL.
  - On accept with cmd_bcnt==0: stay in IDLE, pulse done next cycle, emit no word.
- FILL:
  - fifo_rd_en = !fifo_empty, combinational, only in FILL.
  - On a pop: out_data lane[lane] <= fifo_rd_data, out_be[lane] <= 1, remaining <= remaining-1, lane <= lane+1 (wraps mod NB).
  - If the pop fills lane NB-1 or remaining==1: go to HOLD, out_valid<=1, out_last<=(remaining==1).
  - fifo_empty stalls FILL indefinitely; no timeout.
- HOLD:
  - out_valid=1; out_data, out_be and out_last are stable until accepted. No FIFO pops in HOLD.
  - On out_valid && out_ready with out_last=0: clear out_data/out_be, lane=0, out_valid<=0, go to FILL.
  - On out_valid && out_ready with out_last=1: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Unused lanes of a partial final word are 0 with out_be=0.
- Latency: the first byte is popped in the cycle after cmd accept (if FIFO non-empty). A word is presented the cycle after its final pop.
- Peak throughput: NB bytes per NB+1 cycles when out_ready is held high.
- Arithmetic: remaining is BCW bits and never underflows (leaves FILL at 1). Max command is 2^BCW-1 bytes.
- Flush:
  - Has priority over everything.
  - Next edge: state=IDLE, out_valid=0, out_be=0, out_data=0, out_last=0, done=0, remaining=0.
  - fifo_rd_en is forced 0 in the flush cycle.
  - Command handshake in the flush cycle is ignored.
- Reset mid-operation: immediate return to reset values; no done.
- Protocol rules:
  - fifo_rd_en is never asserted while fifo_empty=1.
  - out_valid never deasserts without out_ready.
  - A new command is only accepted in IDLE.

Test Plan:
- bcnt=8, NB=4, FIFO preloaded 0x01..0x08, out_ready=1 -> words 0x04030201 (be=1111, last=0) then 0x08070605 (be=1111, last=1); done pulses once; 8 pops total.
- bcnt=6, FIFO preloaded 0xA0..0xA5 -> words 0xA3A2A1A0 (be=1111, last=0) then 0x0000A5A4 (be=0011, last=1).
- bcnt=3, FIFO empty, push one byte every 5 cycles (0x11,0x22,0x33) -> fifo_rd_en only while non-empty; word 0x00332211, be=0111, last=1.
- bcnt=4, out_ready=0 for 10 cycles after out_valid -> out_data stable; no pops during hold; accepted on out_ready=1; done follows next cycle.
- bcnt=0 -> cmd accepted; no out_valid; done pulses one cycle; FIFO untouched.
- bcnt=16, flush asserted after 5 pops -> next cycle busy=0, out_valid=0, no done. A following bcnt=4 command runs normally.

Source files
------------

// File: rtl/fifo_word_rdr.sv
// Drains a byte-wide FWFT FIFO per byte-count command and packs bytes little-endian into NB-byte words.
// Latency: first pop the cycle after cmd accept; each word is presented the cycle after its final pop.
// Backpressure: out_ready low holds the word in HOLD with no FIFO pops; an empty FIFO stalls FILL.
module fifo_word_rdr #(
    parameter int W   = 8,
    parameter int NB  = 4,
    parameter int BCW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [BCW-1:0]  cmd_bcnt,
    input  logic            fifo_empty,
    input  logic [W-1:0]    fifo_rd_data,
    output logic            fifo_rd_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NB*W-1:0] out_data,
    output logic [NB-1:0]   out_be,
    output logic            out_last,
    output logic            busy,
    output logic            done
);
    localparam int NBW = $clog2(NB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [BCW-1:0]  rem_q, rem_d;
    logic [NBW-1:0]  lane_q, lane_d;
    logic [NB*W-1:0] data_q, data_d;
    logic [NB-1:0]   be_q, be_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    logic pop;
    logic cmd_acc;
    logic out_acc;
    logic last_byte;
    logic last_lane;

    assign pop       = (state_q == ST_FILL) && !fifo_empty && !flush;
    assign cmd_acc   = cmd_valid && cmd_rdy_q && (state_q == ST_IDLE) && !flush;
    assign out_acc   = valid_q && out_ready;
    assign last_byte = (rem_q == BCW'(1));
    assign last_lane = (lane_q == NBW'(NB - 1));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lane_d  = lane_q;
        data_d  = data_q;
        be_d    = be_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            lane_d  = '0;
            data_d  = '0;
            be_d    = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        if (cmd_bcnt != '0) begin
                            rem_d   = cmd_bcnt;
                            lane_d  = '0;
                            data_d  = '0;
                            be_d    = '0;
                            state_d = ST_FILL;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (pop) begin
                        for (int k = 0; k < NB; k++) begin
                            if (lane_q == NBW'(k)) begin
                                data_d[k*W +: W] = fifo_rd_data;
                                be_d[k]          = 1'b1;
                            end
                        end
                        rem_d  = rem_q - 1'b1;
                        lane_d = lane_q + 1'b1;
                        // Leaving FILL at remaining==1 keeps the counter from ever underflowing.
                        if (last_lane || last_byte) begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                            last_d  = last_byte;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_acc) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        be_d    = '0;
                        lane_d  = '0;
                        if (last_q) begin
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        cmd_rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            be_q      <= be_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd_ready  = cmd_rdy_q;
    assign fifo_rd_en = pop;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_be     = be_q;
    assign out_last   = last_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_be)));

endmodule

// File: tb/tb_fifo_word_rdr.sv
// Bench for fifo_word_rdr: queue-based FWFT FIFO, word-level reference model, randomized traffic.
module tb_fifo_word_rdr;
    localparam int W   = 8;
    localparam int NB  = 4;
    localparam int BCW = 16;

    typedef struct packed {
        logic [NB*W-1:0] data;
        logic [NB-1:0]   be;
        logic            last;
    } word_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [BCW-1:0]  cmd_bcnt;
    logic            fifo_empty;
    logic [W-1:0]    fifo_rd_data;
    logic            fifo_rd_en;
    logic            out_valid;
    logic            out_ready;
    logic [NB*W-1:0] out_data;
    logic [NB-1:0]   out_be;
    logic            out_last;
    logic            busy;
    logic            done;

    fifo_word_rdr #(.W(W), .NB(NB), .BCW(BCW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bcnt(cmd_bcnt),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_be(out_be), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fq[$];
    logic [W-1:0] feed_q[$];
    logic [W-1:0] src_q[$];
    word_t        got_q[$];
    word_t        exp_q[$];

    int    n_cmp = 0;
    int    n_fail = 0;
    int    pops, done_cnt, proto_err, vld_cnt, acc_cmd;
    int    cyc = 0;
    int    acc_cyc, done_cyc, cmd_cyc;
    bit    hold_pend;
    bit    tmo;
    word_t held;

    // One clock cycle: drive FIFO view, sample just before the edge, then wait for the next negedge.
    task automatic step();
        word_t now_w;
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() == 0) ? '0 : fq[0];
        #1;
        now_w = {out_data, out_be, out_last};
        if (hold_pend && !(out_valid && now_w == held)) proto_err++;
        hold_pend = out_valid && !out_ready && !flush;
        held      = now_w;
        if (fifo_rd_en) begin
            if (fq.size() == 0) proto_err++;
            else begin
                void'(fq.pop_front());
                pops++;
            end
        end
        if (out_valid) vld_cnt++;
        if (out_valid && out_ready && !flush) begin
            got_q.push_back(now_w);
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready && !flush) acc_cmd++;
        cyc++;
        @(negedge clk);
    endtask

    // Reference: byte i of the command lands in word i/NB, lane i%NB; final word carries last.
    task automatic load_exp(int bcnt);
        int nw;
        word_t e;
        exp_q.delete();
        nw = (bcnt + NB - 1) / NB;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int k = 0; k < NB; k++) begin
                if (w * NB + k < bcnt) begin
                    e.data[k*W +: W] = src_q[w * NB + k];
                    e.be[k] = 1'b1;
                end
            end
            e.last = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start(int bcnt);
        got_q.delete();
        pops = 0; done_cnt = 0; proto_err = 0; vld_cnt = 0; acc_cmd = 0;
        hold_pend = 0; acc_cyc = -1; done_cyc = -1;
        cmd_valid = 1'b1;
        cmd_bcnt  = BCW'(bcnt);
        cmd_cyc   = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_bcnt  = '0;
    endtask

    task automatic run(int maxc, bit rnd);
        int n = 0;
        tmo = 0;
        while (done_cnt == 0 && n < maxc) begin
            if (rnd) out_ready = ($urandom % 4) != 0;
            if (feed_q.size() > 0 && (!rnd || ($urandom % 3) != 0)) fq.push_back(feed_q.pop_front());
            step();
            n++;
        end
        if (done_cnt == 0) tmo = 1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_bcnt = '0;
        out_ready = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++;
        if ({cmd_ready, fifo_rd_en, out_valid, out_last, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {cmd_ready, fifo_rd_en, out_valid, out_last, busy, done});
        end
        n_cmp++;
        if (out_data !== '0 || out_be !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%b expected 0/0", out_data, out_be);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got rdy=%b busy=%b expected rdy=1 busy=0", cmd_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_full_words();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        fq = src_q; out_ready = 1'b1;
        load_exp(8);
        start(8); run(100, 0); step(); step();
        n_cmp++;
        if (tmo || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL full_count: got %0d words (tmo=%0d) expected %0d", got_q.size(), tmo, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() != 2 || got_q[1].data !== 32'h08070605 || got_q[1].last !== 1'b1) begin
            n_fail++;
            $display("FAIL full_const: got %0d words expected word1 08070605 last=1", got_q.size());
        end
        n_cmp++;
        if (done_cnt != 1 || pops != 8 || acc_cmd != 1 || proto_err != 0) begin
            n_fail++;
            $display("FAIL full_side: got done=%0d pops=%0d acc=%0d perr=%0d expected 1/8/1/0", done_cnt, pops, acc_cmd, proto_err);
        end
        n_cmp++;
        if (done_cyc - cmd_cyc != 2 * (NB + 1) + 1) begin
            n_fail++;
            $display("FAIL full_latency: got %0d cycles expected %0d", done_cyc - cmd_cyc, 2 * (NB + 1) + 1);
        end
    endtask

    task automatic test_partial();
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        fq = src_q; out_ready = 1'b1;
        load_exp(6);
        start(6); run(100, 0); step();
        n_cmp++;
        if (tmo || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL part_count: got %0d words (tmo=%0d) expected 2", got_q.size(), tmo);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL part_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() == 2 && (got_q[1].data !== 32'h0000A5A4 || got_q[1].be !== 4'b0011)) begin
            n_fail++;
            $display("FAIL part_tail: got %h be=%b expected 0000a5a4 be=0011", got_q[1].data, got_q[1].be);
        end
    endtask

    task automatic test_trickle();
        logic [W-1:0] tv[3];
        int pushed = 0;
        int n = 0;
        tv[0] = 8'h11; tv[1] = 8'h22; tv[2] = 8'h33;
        fq.delete(); out_ready = 1'b1;
        start(3);
        while (done_cnt == 0 && n < 60) begin
            if (n % 5 == 4 && pushed < 3) begin
                fq.push_back(tv[pushed]);
                pushed++;
            end
            step();
            n++;
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {32'h00332211, 4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL trickle_word: got %0d words first %h expected 00332211/0111/1", got_q.size(), got_q.size() ? got_q[0] : '0);
        end
        n_cmp++;
        if (pops != 3 || proto_err != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL trickle_side: got pops=%0d perr=%0d done=%0d expected 3/0/1", pops, proto_err, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int p0;
        logic [NB*W-1:0] w0;
        src_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        fq = src_q; out_ready = 1'b0;
        start(4);
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        p0 = pops; w0 = out_data;
        repeat (10) step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== w0 || w0 !== 32'hC3C2C1C0 || pops != p0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b data=%h pops=%0d perr=%0d expected v=1 c3c2c1c0 pops=%0d", out_valid, out_data, pops, proto_err, p0);
        end
        out_ready = 1'b1;
        step(); step();
        n_cmp++;
        if (done_cnt != 1 || done_cyc != acc_cyc + 1 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_done: got done=%0d dcyc=%0d acyc=%0d words=%0d expected 1/acyc+1/1", done_cnt, done_cyc, acc_cyc, got_q.size());
        end
    endtask

    task automatic test_zero();
        fq = '{8'h5A, 8'h5B}; out_ready = 1'b1;
        start(0); step(); step(); step();
        n_cmp++;
        if (acc_cmd != 1 || done_cnt != 1 || done_cyc != cmd_cyc + 1 || vld_cnt != 0 || pops != 0 || fq.size() != 2) begin
            n_fail++;
            $display("FAIL zero_cmd: got acc=%0d done=%0d dly=%0d vld=%0d pops=%0d fifo=%0d expected 1/1/1/0/0/2",
                     acc_cmd, done_cnt, done_cyc - cmd_cyc, vld_cnt, pops, fq.size());
        end
        fq.delete();
    endtask

    task automatic test_flush();
        int n = 0;
        src_q.delete();
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h40 + i));
        fq = src_q; out_ready = 1'b1;
        start(16);
        while (pops < 5 && n < 50) begin
            step();
            n++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_be !== '0 || pops != 5) begin
            n_fail++;
            $display("FAIL flush_state: got busy=%b v=%b be=%b pops=%0d expected 0/0/0/5", busy, out_valid, out_be, pops);
        end
        cmd_valid = 1'b1; cmd_bcnt = BCW'(4); flush = 1'b1;
        step();
        cmd_valid = 1'b0; flush = 1'b0;
        step(); step();
        n_cmp++;
        if (busy !== 1'b0 || done_cnt != 0 || acc_cmd != 1) begin
            n_fail++;
            $display("FAIL flush_cmd: got busy=%b done=%0d acc=%0d expected 0/0/1", busy, done_cnt, acc_cmd);
        end
        src_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        fq = src_q;
        start(4); run(50, 0); step();
        n_cmp++;
        if (tmo || got_q.size() != 1 || got_q[0] !== {32'hE3E2E1E0, 4'b1111, 1'b1} || done_cnt != 1) begin
            n_fail++;
            $display("FAIL flush_after: got %0d words done=%0d tmo=%0d expected e3e2e1e0/1111/1", got_q.size(), done_cnt, tmo);
        end
    endtask

    task automatic test_reset_mid();
        src_q = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98};
        fq = src_q; out_ready = 1'b1;
        start(8); step(); step();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || fifo_rd_en !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b v=%b rd=%b rdy=%b expected 0/0/0/0", busy, out_valid, fifo_rd_en, cmd_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(); step();
        n_cmp++;
        if (done_cnt != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after: got done=%0d rdy=%b expected 0/1", done_cnt, cmd_ready);
        end
        fq.delete();
    endtask

    task automatic test_random();
        int bcnt;
        for (int it = 0; it < 12; it++) begin
            bcnt = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 23));
            src_q.delete();
            for (int i = 0; i < bcnt; i++) src_q.push_back(8'($urandom));
            feed_q = src_q; fq.delete();
            load_exp(bcnt);
            start(bcnt); run(400, 1); step();
            n_cmp++;
            if (tmo || got_q.size() != exp_q.size() || done_cnt != 1 || pops != bcnt || proto_err != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_side: bcnt=%0d words=%0d/%0d done=%0d pops=%0d perr=%0d tmo=%0d",
                         it, bcnt, got_q.size(), exp_q.size(), done_cnt, pops, proto_err, tmo);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_word%0d: got %h expected %h", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_trickle();
        test_backpressure();
        test_zero();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
